aes_round_sched: RTL and testbench
==================================

Name: aes_round_sched

Overview:
Iterative AES round scheduler. Accepts one 128-bit block with an encrypt/decrypt flag and owns the 128-bit state register. It sequences a shared external combinational round datapath (SubBytes/ShiftRows/MixColumns or their inverses) and fetches round keys from the key store through a request/valid handshake. The result is presented on a valid/ready output port; it sits between the block I/O wrapper and the round datapath plus key expansion.

Parameters:
NR, 10, number of rounds; legal values are 10, 12 and 14.
KIW, 4, width of the round-key index; must satisfy 2**KIW > NR.

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  synchronous, active-low reset
inValid  input  1  input block offered
inReady  output  1  scheduler idle and able to accept
dataIn  input  128  plaintext or ciphertext
invIn  input  1  0 = encrypt, 1 = decrypt; sampled with dataIn
keyReq  output  1  round-key request
keyRound  output  KIW  requested round-key index
keyValid  input  1  roundKey valid for keyRound
roundKey  input  128  round key
rfIn  output  128  state to the round datapath (always the state register)
rfInv  output  1  inverse-round select (latched inv)
rfLast  output  1  final round; datapath omits (Inv)MixColumns
rfOut  input  128  round datapath result (combinational)
outValid  output  1  result available
outReady  input  1  consumer accepts
dataOut  output  128  result (the state register)

Behaviour:
- Reset (rst_n = 0 at a clk edge) values:
  - state = IDLE; state register = 0; inv = 0; round counter = 0.
  - inReady = 1; keyReq = 0; outValid = 0; rfLast = 0.
  - Reset mid-operation aborts the block with no output.
- FSM has four states: IDLE, KEY0, ROUND, DONE.
- IDLE:
  - inReady = 1.
  - On inValid: latch dataIn into the state register and invIn into inv.
  - Counter = 0 for encrypt, NR for decrypt. Go to KEY0.
- KEY0:
  - keyReq = 1, keyRound = counter.
  - On keyValid: state <= state ^ roundKey; step the counter (+1 encrypt, -1 decrypt). Go to ROUND.
- ROUND:
  - keyReq = 1, keyRound = counter.
  - rfLast = 1 when counter == NR (encrypt) or counter == 0 (decrypt).
  - On keyValid: state <= rfOut ^ roundKey.
  - If rfLast, go to DONE; otherwise step the counter.
- DONE:
  - outValid = 1; dataOut is stable.
  - On outReady: go to IDLE. inReady rises the following cycle; there is no same-cycle accept.
- Key handshake:
  - keyReq and keyRound are held stable until keyValid is sampled high.
  - keyValid while keyReq = 0 is ignored.
  - The state register does not change on stall cycles.
- Latency: with keyValid tied high, NR+1 cycles from the accept edge to outValid = 1.
- inValid outside IDLE is ignored; inReady = 0 there.
- outReady outside DONE is ignored.
- rfInv = inv at all times; rfIn = state register.
- Decrypt uses the equivalent-inverse order: keys NR..0, and the round datapath applies InvShiftRows/InvSubBytes(/InvMixColumns).

Optional Feature:
AES_SCHED_STALL_CNT_EN.
- Defined: adds output port stallCnt [15:0]. It counts cycles with keyReq = 1 and keyValid = 0, saturates at 16'hFFFF, and clears on reset and on each accept in IDLE.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package aes_pkg holds:
  - state enum (IDLE, KEY0, ROUND, DONE);
  - NR_128 = 10, NR_192 = 12, NR_256 = 14;
  - AES_BLK_W = 128.
- Sub-module aes_round_cnt: loadable up/down counter of width KIW.
  - Inputs: load value, direction, step.
  - Outputs: count, and isLast (count == NR for up, count == 0 for down).

Test Plan:
- Encrypt, keyValid tied 1, FIPS-197 App. C.1: dataIn = 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f expanded by the bench model.
  - dataOut = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - outValid exactly 11 cycles after accept.
  - keyRound sequence 0..10; rfLast only on index 10.
- Decrypt with the same key, dataIn = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - dataOut = 00112233445566778899aabbccddeeff.
  - keyRound sequence 10..0; rfInv = 1 throughout.
- Random keyValid stalls (30%) on the encrypt vector.
  - Same ciphertext; keyRound held stable across stalls.
  - With the macro defined, stallCnt equals the number of injected stall cycles.
- Back-pressure: outReady held 0 for 5 cycles.
  - outValid and dataOut held stable; inReady = 0.
  - inValid pulses in that window are ignored.
  - Accept occurs only on the cycle after the outReady handshake.
- rst_n asserted during ROUND at keyRound = 5.
  - Next cycle: inReady = 1, keyReq = 0, outValid = 0, dataOut = 0.
  - A fresh encrypt then produces 69c4e0d86a7b0430d8cdb78070b4c55a.
- NR = 14, FIPS-197 C.3: key 00..1f, dataIn = 00112233445566778899aabbccddeeff.
  - dataOut = 8ea2b7ca516745bfeafc49904b496089.
  - Latency 15 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round scheduler.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY0  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } aes_state_e;

  localparam int NR_128    = 10;
  localparam int NR_192    = 12;
  localparam int NR_256    = 14;
  localparam int AES_BLK_W = 128;

endpackage

// File: rtl/aes_round_cnt.sv
// Loadable up/down round-key index counter with a final-round flag.
module aes_round_cnt
  import aes_pkg::*;
#(
  parameter int NR  = NR_128,
  parameter int KIW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [KIW-1:0] load_val,
  input  logic           up,
  input  logic           step,
  output logic [KIW-1:0] count,
  output logic           is_last
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (step) begin
      count <= up ? count + 1'b1 : count - 1'b1;
    end
  end

  // Encrypt walks keys 0..NR, decrypt walks NR..0.
  assign is_last = up ? (count == KIW'(NR)) : (count == '0);

endmodule

// File: rtl/aes_round_sched.sv
// Iterative AES round scheduler: owns the state register, sequences the external
// round datapath and key store. Optional AES_SCHED_STALL_CNT_EN adds stallCnt.
//
//   state | meaning
//   IDLE  | ready for a new block
//   KEY0  | initial AddRoundKey, waiting for key 0 (enc) or NR (dec)
//   ROUND | one datapath round per accepted key
//   DONE  | result held on dataOut until outReady
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int NR  = NR_128,
  parameter int KIW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [AES_BLK_W-1:0] dataIn,
  input  logic                 invIn,
  output logic                 keyReq,
  output logic [KIW-1:0]       keyRound,
  input  logic                 keyValid,
  input  logic [AES_BLK_W-1:0] roundKey,
  output logic [AES_BLK_W-1:0] rfIn,
  output logic                 rfInv,
  output logic                 rfLast,
  input  logic [AES_BLK_W-1:0] rfOut,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [AES_BLK_W-1:0] dataOut
`ifdef AES_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]          stallCnt
`endif
);

  aes_state_e           state;
  logic [AES_BLK_W-1:0] blk;
  logic                 inv;
  logic                 accept;
  logic                 cnt_step;
  logic                 cnt_last;
  logic [KIW-1:0]       cnt;
  logic [KIW-1:0]       cnt_init;

  assign accept   = (state == IDLE) && inValid;
  assign cnt_init = invIn ? KIW'(NR) : '0;
  assign cnt_step = keyValid && ((state == KEY0) || ((state == ROUND) && !cnt_last));

  aes_round_cnt #(
    .NR  (NR),
    .KIW (KIW)
  ) u_round_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (cnt_init),
    .up       (!inv),
    .step     (cnt_step),
    .count    (cnt),
    .is_last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      blk      <= '0;
      inv      <= 1'b0;
      inReady  <= 1'b1;
      keyReq   <= 1'b0;
      outValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            blk     <= dataIn;
            inv     <= invIn;
            inReady <= 1'b0;
            keyReq  <= 1'b1;
            state   <= KEY0;
          end
        end
        KEY0: begin
          if (keyValid) begin
            blk   <= blk ^ roundKey;
            state <= ROUND;
          end
        end
        ROUND: begin
          if (keyValid) begin
            blk <= rfOut ^ roundKey;
            if (cnt_last) begin
              keyReq   <= 1'b0;
              outValid <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          // inReady only comes back after this edge, so no same-cycle accept.
          if (outReady) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign keyRound = cnt;
  assign rfIn     = blk;
  assign dataOut  = blk;
  assign rfInv    = inv;
  assign rfLast   = (state == ROUND) && cnt_last;

`ifdef AES_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      stallCnt <= '0;
    end else if (keyReq && !keyValid && (stallCnt != 16'hFFFF)) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: the bench models the round datapath and key store.
module tb_aes_round_sched;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, inv_in, key_req, key_valid, rf_inv, rf_last, out_valid, out_ready;
  logic [3:0]   key_round;
  logic [127:0] data_in, round_key, rf_in, rf_out, data_out;
  logic         in_valid14, in_ready14, key_req14, rf_inv14, rf_last14, out_valid14, out_ready14;
  logic [3:0]   key_round14;
  logic [127:0] round_key14, rf_in14, rf_out14, data_out14;
`ifdef AES_SCHED_STALL_CNT_EN
  logic [15:0]  stall_cnt, stall_cnt14;
`endif

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [31:0]  w   [60];
  logic [127:0] ek10 [11];
  logic [127:0] dk10 [11];
  logic [127:0] ek14 [15];

  int n_checks = 0;
  int n_errors = 0;
  logic stall_mode = 1'b0;

  aes_round_sched #(.NR(10), .KIW(4)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(in_ready), .dataIn(data_in),
    .invIn(inv_in), .keyReq(key_req), .keyRound(key_round), .keyValid(key_valid),
    .roundKey(round_key), .rfIn(rf_in), .rfInv(rf_inv), .rfLast(rf_last), .rfOut(rf_out),
    .outValid(out_valid), .outReady(out_ready), .dataOut(data_out)
`ifdef AES_SCHED_STALL_CNT_EN
    , .stallCnt(stall_cnt)
`endif
  );

  aes_round_sched #(.NR(14), .KIW(4)) dut14 (
    .clk(clk), .rst_n(rst_n), .inValid(in_valid14), .inReady(in_ready14), .dataIn(PT),
    .invIn(1'b0), .keyReq(key_req14), .keyRound(key_round14), .keyValid(1'b1),
    .roundKey(round_key14), .rfIn(rf_in14), .rfInv(rf_inv14), .rfLast(rf_last14), .rfOut(rf_out14),
    .outValid(out_valid14), .outReady(out_ready14), .dataOut(data_out14)
`ifdef AES_SCHED_STALL_CNT_EN
    , .stallCnt(stall_cnt14)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    if (a == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   o;
    logic [127:0] r;
    r = '0;
    if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o = o ^ gmul(m[(j-rr+4)%4], a[j]);
        r[127-8*(4*c+rr) -: 8] = o;
      end
    end
    return r;
  endfunction

  // Encrypt: SubBytes/ShiftRows/MixColumns; decrypt: InvShiftRows/InvSubBytes/InvMixColumns.
  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic inv, input logic last);
    logic [127:0] t;
    t = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!inv) t[127-8*(r+4*c) -: 8] = sb[s[127-8*(r+4*((c+r)%4)) -: 8]];
        else      t[127-8*(r+4*c) -: 8] = isb[s[127-8*(r+4*((c-r+4)%4)) -: 8]];
      end
    end
    return last ? t : mix(t, inv);
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 60; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  assign round_key   = rf_inv ? dk10[key_round] : ek10[key_round];
  assign rf_out      = aes_rnd(rf_in, rf_inv, rf_last);
  assign round_key14 = ek14[key_round14];
  assign rf_out14    = aes_rnd(rf_in14, rf_inv14, rf_last14);

  always @(posedge clk) begin
    #1;
    key_valid = stall_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // Observe key handshakes and stall behaviour between clock edges.
  logic [5:0]   kq [$];
  int           hold_viol = 0;
  int           stall_seen = 0;
  logic         prev_stall = 1'b0;
  logic [3:0]   prev_round = '0;
  logic [127:0] prev_rf = '0;
  always @(negedge clk) begin
    if (key_req && key_valid) kq.push_back({rf_inv, rf_last, key_round});
    if (prev_stall && (key_round != prev_round || rf_in != prev_rf)) hold_viol++;
    if (key_req && !key_valid) stall_seen++;
    prev_stall = key_req && !key_valid;
    prev_round = key_round;
    prev_rf    = rf_in;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] din, input logic inv);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("send_ready", in_ready, 1'b1);
    data_in  = din;
    inv_in   = inv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int lat);
    lat = 0;
    while (!out_valid && lat < max_cyc) begin tick(); lat++; end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, kb, h0, s0;
    logic found;
    rst_n = 1'b0; in_valid = 1'b0; inv_in = 1'b0; data_in = '0; out_ready = 1'b0;
    in_valid14 = 1'b0; out_ready14 = 1'b0;

    for (int i = 0; i < 256; i++) begin
      sb[i]      = affine(ginv(8'(i)));
      isb[sb[i]] = 8'(i);
    end
    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    for (int r = 0; r < 11; r++) begin
      ek10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      dk10[r] = (r == 0 || r == 10) ? ek10[r] : mix(ek10[r], 1'b1);
    end
    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    for (int r = 0; r < 15; r++) ek14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    repeat (3) tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_key_req", key_req, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_rf_last", rf_last, 1'b0);
    check("rst_rf_inv", rf_inv, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst14_in_ready", in_ready14, 1'b1);
    rst_n = 1'b1;
    tick();

    // Encrypt, keys always valid
    kb = kq.size();
    send(PT, 1'b0);
    wait_done(40, lat);
    check("enc_lat", lat, 11);
    check("enc_data", data_out, CT);
    check("enc_in_ready_done", in_ready, 1'b0);
    check("enc_keyseq_len", kq.size() - kb, 11);
    for (int i = 0; i < 11; i++)
      if (kb + i < kq.size()) check("enc_keyseq", kq[kb+i], {1'b0, i == 10, 4'(i)});
    drain();
    check("enc_in_ready_after", in_ready, 1'b1);

    // Decrypt with equivalent-inverse keys
    kb = kq.size();
    send(CT, 1'b1);
    wait_done(40, lat);
    check("dec_lat", lat, 11);
    check("dec_data", data_out, PT);
    check("dec_keyseq_len", kq.size() - kb, 11);
    for (int i = 0; i < 11; i++)
      if (kb + i < kq.size()) check("dec_keyseq", kq[kb+i], {1'b1, i == 10, 4'(10 - i)});
    drain();

    // Random key stalls
    kb = kq.size(); h0 = hold_viol; s0 = stall_seen;
    stall_mode = 1'b1;
    send(PT, 1'b0);
    wait_done(400, lat);
    stall_mode = 1'b0;
    check("stall_data", data_out, CT);
    check("stall_hold", hold_viol - h0, 0);
    check("stall_keyseq_len", kq.size() - kb, 11);
`ifdef AES_SCHED_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stall_seen - s0);
`endif
    drain();

    // Output back-pressure with ignored inValid pulses
    send(PT, 1'b0);
    wait_done(40, lat);
    data_in = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    inv_in  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      tick();
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_data", data_out, CT);
      check("bp_in_ready", in_ready, 1'b0);
    end
    data_in = CT; inv_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_hs_in_ready", in_ready, 1'b1);
    check("bp_hs_no_accept", key_req, 1'b0);
    tick();
    in_valid = 1'b0;
    check("bp_accept_key_req", key_req, 1'b1);
    check("bp_accept_round", key_round, 4'd10);
    wait_done(40, lat);
    check("bp_dec_data", data_out, PT);
    drain();

    // Reset in the middle of ROUND
    send(PT, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (key_req && key_round == 4'd5) found = 1'b1;
      else tick();
    end
    check("rst_mid_found", found, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_in_ready", in_ready, 1'b1);
    check("rst_mid_key_req", key_req, 1'b0);
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_data", data_out, '0);
    send(PT, 1'b0);
    wait_done(40, lat);
    check("rst_mid_enc_lat", lat, 11);
    check("rst_mid_enc_data", data_out, CT);
    drain();

    // NR = 14, AES-256
    in_valid14 = 1'b1;
    tick();
    in_valid14 = 1'b0;
    lat = 0;
    while (!out_valid14 && lat < 40) begin tick(); lat++; end
    check("nr14_lat", lat, 15);
    check("nr14_data", data_out14, CT14);
    out_ready14 = 1'b1;
    tick();
    out_ready14 = 1'b0;
    check("nr14_in_ready", in_ready14, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
